// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and defaults for the instruction/data bus
//               arbiter: FSM state encoding, memory access size codes and
//               the default anti-starvation limit.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // Consecutive data grants tolerated while a fetch is waiting.
    localparam int unsigned AGE_LIMIT_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_if
// Description : Bundle of the instruction requester, data requester and
//               shared memory-port signals around the bus arbiter.
//               slave  : arbiter view (serves requesters, drives memory port)
//               master : environment view (requesters and memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if;
    import arb_pkg::*;

    // instruction requester
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_data_ok;
    logic [31:0] i_data;

    // data requester
    logic        d_valid;
    logic [63:0] d_addr;
    msize_t      d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_data_ok;
    logic [63:0] d_rdata;

    // shared memory port
    logic        c_valid;
    logic [63:0] c_addr;
    msize_t      c_size;
    logic [7:0]  c_strobe;
    logic [63:0] c_wdata;
    logic        c_ready;
    logic [63:0] c_rdata;

    modport slave (
        input  i_valid, i_addr,
        input  d_valid, d_addr, d_size, d_strobe, d_wdata,
        input  c_ready, c_rdata,
        output i_data_ok, i_data,
        output d_data_ok, d_rdata,
        output c_valid, c_addr, c_size, c_strobe, c_wdata
    );

    modport master (
        output i_valid, i_addr,
        output d_valid, d_addr, d_size, d_strobe, d_wdata,
        output c_ready, c_rdata,
        input  i_data_ok, i_data,
        input  d_data_ok, d_rdata,
        input  c_valid, c_addr, c_size, c_strobe, c_wdata
    );

endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Two-requester arbiter sharing one single-beat memory port
//               between instruction fetch and data access. Data wins ties
//               unless the fetch has been passed over AGE_LIMIT times in a
//               row. The winner's request is latched onto the port and held
//               until the memory answers with c_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import arb_pkg::*;
#(
    // Must fit the 3-bit age counter (0..7).
    parameter int unsigned AGE_LIMIT = AGE_LIMIT_DEFAULT
) (
    input  wire          clk,
    input  wire          rst,
    bus_arbiter_if.slave bus
);

    localparam logic [2:0] AGE_MAX = 3'(AGE_LIMIT);

    arb_state_t state;
    logic [2:0] age_cnt;
    logic       pick_d;
    logic       pick_i;

    // Priority pick: data first, unless the waiting fetch has aged out.
    always_comb begin
        pick_d = bus.d_valid && !(bus.i_valid && (age_cnt == AGE_MAX));
        pick_i = bus.i_valid && !pick_d;
    end

    // Grant FSM with the latched memory-port request; reset abandons any
    // transaction in flight and clears the port immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            age_cnt      <= 3'd0;
            bus.c_valid  <= 1'b0;
            bus.c_addr   <= 64'd0;
            bus.c_size   <= MSIZE1;
            bus.c_strobe <= 8'd0;
            bus.c_wdata  <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state        <= SERVE_D;
                        bus.c_valid  <= 1'b1;
                        bus.c_addr   <= bus.d_addr;
                        bus.c_size   <= bus.d_size;
                        bus.c_strobe <= bus.d_strobe;
                        bus.c_wdata  <= bus.d_wdata;
                        // Only a grant that passes over a waiting fetch ages it.
                        if (!bus.i_valid) begin
                            age_cnt <= 3'd0;
                        end else if (age_cnt < AGE_MAX) begin
                            age_cnt <= age_cnt + 3'd1;
                        end
                    end else if (pick_i) begin
                        state        <= SERVE_I;
                        bus.c_valid  <= 1'b1;
                        bus.c_addr   <= bus.i_addr;
                        bus.c_size   <= MSIZE4;
                        bus.c_strobe <= 8'd0;
                        bus.c_wdata  <= 64'd0;
                        age_cnt      <= 3'd0;
                    end else begin
                        // Nothing pending here means no fetch is waiting.
                        age_cnt <= 3'd0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.c_ready) begin
                        state       <= IDLE;
                        bus.c_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.c_valid <= 1'b0;
                end
            endcase
        end
    end

    // Completion pulses follow c_ready in the owning state; read data is
    // steered straight from the memory port.
    always_comb begin
        bus.i_data_ok = (state == SERVE_I) && bus.c_ready;
        bus.d_data_ok = (state == SERVE_D) && bus.c_ready;
        bus.i_data    = bus.c_addr[2] ? bus.c_rdata[63:32] : bus.c_rdata[31:0];
        bus.d_rdata   = bus.c_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter. A transaction-level
//               model tracks which requester owns the port and how often a
//               waiting fetch has been passed over; every cycle the DUT is
//               compared against it. Directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
    import arb_pkg::*;

    localparam int AGE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    int          mem_wait  = 0;
    int          mem_cnt   = 0;
    logic [63:0] rdata_val = 64'd0;

    bus_arbiter_if bus ();

    bus_arbiter #(.AGE_LIMIT(AGE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a completion; returns the cycle index relative to
    // the cycle the call was made in, stopping at that cycle's negedge.
    task automatic wait_ok(input bit instr, output int cyc);
        cyc = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (instr ? bus.i_data_ok : bus.d_data_ok) begin
                cyc = k;
                break;
            end
        end
        if (cyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ok timeout (instr=%0d) at %0t", instr, $time);
        end
    endtask

    // Memory model: answers after mem_wait stall cycles of a request.
    initial begin
        bus.c_ready = 1'b0;
        bus.c_rdata = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.c_valid) begin
                if (mem_cnt >= mem_wait) begin
                    bus.c_ready = 1'b1;
                    mem_cnt     = 0;
                end else begin
                    bus.c_ready = 1'b0;
                    mem_cnt++;
                end
            end else begin
                bus.c_ready = 1'b0;
                mem_cnt     = 0;
            end
            bus.c_rdata = rdata_val;
        end
    end

    // ---------------- transaction-level reference model ----------------
    bit          m_busy   = 1'b0;
    bit          m_is_i   = 1'b0;
    int          m_passed = 0;
    logic [63:0] m_addr   = 64'd0;
    msize_t      m_size   = MSIZE1;
    logic [7:0]  m_strobe = 8'd0;
    logic [63:0] m_wdata  = 64'd0;
    bit          fetch_starved;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_c_valid", 64'(bus.c_valid), 64'd0);
            check("rst_c_addr", bus.c_addr, 64'd0);
            check("rst_c_strobe", 64'(bus.c_strobe), 64'd0);
            check("rst_c_wdata", bus.c_wdata, 64'd0);
            check("rst_i_data_ok", 64'(bus.i_data_ok), 64'd0);
            check("rst_d_data_ok", 64'(bus.d_data_ok), 64'd0);
            m_busy   = 1'b0;
            m_passed = 0;
        end else begin
            check("c_valid", 64'(bus.c_valid), 64'(m_busy));
            if (m_busy) begin
                check("c_addr", bus.c_addr, m_addr);
                check("c_size", 64'(bus.c_size), 64'(m_size));
                check("c_strobe", 64'(bus.c_strobe), 64'(m_strobe));
                check("c_wdata", bus.c_wdata, m_wdata);
            end
            check("i_data_ok", 64'(bus.i_data_ok), 64'(m_busy && m_is_i && bus.c_ready));
            check("d_data_ok", 64'(bus.d_data_ok), 64'(m_busy && !m_is_i && bus.c_ready));
            if (m_busy && bus.c_ready) begin
                if (m_is_i)
                    check("i_data", 64'(bus.i_data),
                          64'(m_addr[2] ? bus.c_rdata[63:32] : bus.c_rdata[31:0]));
                else
                    check("d_rdata", bus.d_rdata, bus.c_rdata);
            end
            // what the port looks like after the coming edge
            if (m_busy) begin
                if (bus.c_ready) m_busy = 1'b0;
            end else begin
                fetch_starved = bus.i_valid && (m_passed >= AGE);
                if (bus.d_valid && !fetch_starved) begin
                    m_busy   = 1'b1;
                    m_is_i   = 1'b0;
                    m_addr   = bus.d_addr;
                    m_size   = bus.d_size;
                    m_strobe = bus.d_strobe;
                    m_wdata  = bus.d_wdata;
                    m_passed = bus.i_valid ? ((m_passed < AGE) ? m_passed + 1 : AGE) : 0;
                end else if (bus.i_valid) begin
                    m_busy   = 1'b1;
                    m_is_i   = 1'b1;
                    m_addr   = bus.i_addr;
                    m_size   = MSIZE4;
                    m_strobe = 8'd0;
                    m_wdata  = 64'd0;
                    m_passed = 0;
                end else begin
                    m_passed = 0;
                end
            end
        end
    end

    // ---------------------------- stimulus ----------------------------
    int          cyc;
    bit          i_ok [0:5];
    bit          d_ok [0:5];
    bit          cv   [0:5];
    logic [63:0] seq;
    int          n_grants;
    int          ok_cnt;
    int          ok_cyc;
    int          stall_cnt;

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_addr   = 64'd0;
        bus.d_valid  = 1'b0;
        bus.d_addr   = 64'd0;
        bus.d_size   = MSIZE1;
        bus.d_strobe = 8'd0;
        bus.d_wdata  = 64'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_c_valid", 64'(bus.c_valid), 64'd0);
        check("reset_c_size", 64'(bus.c_size), 64'd0);

        // Fetch granted on the first edge after reset, upper word selected.
        step();
        rst         = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_addr  = 64'h0000_0000_8000_0004;
        rdata_val   = 64'h1111_2222_3333_4444;
        mem_wait    = 0;
        wait_ok(1'b1, cyc);
        check("fetch_latency", 64'(cyc), 64'd1);
        check("fetch_c_valid", 64'(bus.c_valid), 64'd1);
        check("fetch_i_data", 64'(bus.i_data), 64'h1111_2222);
        check("fetch_c_size", 64'(bus.c_size), 64'(MSIZE4));
        check("fetch_no_d_ok", 64'(bus.d_data_ok), 64'd0);
        step();
        bus.i_valid = 1'b0;
        step();

        // Fetch dropped mid-service still completes; lower word selected.
        bus.i_valid = 1'b1;
        bus.i_addr  = 64'h1000;
        rdata_val   = 64'hAAAA_BBBB_CCCC_DDDD;
        mem_wait    = 2;
        step();
        step();
        bus.i_valid = 1'b0;
        wait_ok(1'b1, cyc);
        check("dropped_latency", 64'(cyc), 64'd1);
        check("dropped_i_data", 64'(bus.i_data), 64'hCCCC_DDDD);
        step();
        step();

        // Simultaneous requests: data first, one idle bubble, then fetch.
        mem_wait     = 0;
        rdata_val    = 64'h0123_4567_89AB_CDEF;
        bus.i_valid  = 1'b1;
        bus.i_addr   = 64'h3004;
        bus.d_valid  = 1'b1;
        bus.d_addr   = 64'h2000;
        bus.d_size   = MSIZE8;
        bus.d_strobe = 8'h00;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            i_ok[c] = bus.i_data_ok;
            d_ok[c] = bus.d_data_ok;
            cv[c]   = bus.c_valid;
            step();
            if (d_ok[c]) bus.d_valid = 1'b0;
            if (i_ok[c]) bus.i_valid = 1'b0;
        end
        check("both_d_first", 64'(d_ok[1]), 64'd1);
        check("both_no_i_first", 64'(i_ok[1]), 64'd0);
        check("both_bubble", 64'(cv[2]), 64'd0);
        check("both_i_second", 64'(i_ok[3]), 64'd1);
        step();

        // Starvation guard: 4 data grants, 1 fetch, then data again.
        bus.i_valid = 1'b1;
        bus.d_valid = 1'b1;
        seq         = 64'd0;
        n_grants    = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.d_data_ok) begin seq = (seq << 4) | 64'h2; n_grants++; end
            if (bus.i_data_ok) begin seq = (seq << 4) | 64'h1; n_grants++; end
            step();
        end
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        check("age_sequence", seq, 64'h0022_2212);
        check("age_grants", 64'(n_grants), 64'd6);
        step();

        // Stalled store: port stable for 5 stall cycles, one completion.
        mem_wait     = 5;
        bus.d_valid  = 1'b1;
        bus.d_addr   = 64'h4008;
        bus.d_size   = MSIZE8;
        bus.d_strobe = 8'hFF;
        bus.d_wdata  = 64'hDEAD;
        ok_cnt    = 0;
        ok_cyc    = -1;
        stall_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.c_valid && !bus.c_ready) stall_cnt++;
            if (c == 5) check("store_wdata_held", bus.c_wdata, 64'hDEAD);
            if (bus.d_data_ok) begin ok_cnt++; ok_cyc = c; end
            step();
            if (c == 1) begin
                bus.d_wdata = 64'hBEEF;
                bus.d_addr  = 64'h9999;
            end
            if (ok_cyc == c) bus.d_valid = 1'b0;
        end
        check("store_ok_count", 64'(ok_cnt), 64'd1);
        check("store_ok_cycle", 64'(ok_cyc), 64'd6);
        check("store_stall_cycles", 64'(stall_cnt), 64'd5);

        // Reset during a stalled data service abandons it.
        mem_wait     = 50;
        bus.d_valid  = 1'b1;
        bus.d_addr   = 64'h5000;
        bus.d_strobe = 8'h00;
        step();
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_c_valid", 64'(bus.c_valid), 64'd0);
        check("async_rst_c_addr", bus.c_addr, 64'd0);
        check("async_rst_d_ok", 64'(bus.d_data_ok), 64'd0);
        bus.d_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst         = 1'b0;
        mem_wait    = 0;
        rdata_val   = 64'hFEED_FACE_CAFE_BEEF;
        bus.d_valid = 1'b1;
        bus.d_addr  = 64'h6000;
        bus.d_size  = MSIZE2;
        wait_ok(1'b0, cyc);
        check("post_rst_latency", 64'(cyc), 64'd1);
        check("post_rst_d_rdata", bus.d_rdata, 64'hFEED_FACE_CAFE_BEEF);
        check("post_rst_c_addr", bus.c_addr, 64'h6000);
        step();
        bus.d_valid = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter AGE_LIMIT, default 4: maximum consecutive data grants while an instruction request waits.
REQ-002 clk  input  1  clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_valid  input  1  instruction fetch request.
REQ-005 i_addr  input  64  fetch address.
REQ-006 i_data_ok  output  1  one-cycle fetch completion pulse.
REQ-007 i_data  output  32  fetched instruction, valid with i_data_ok.
REQ-008 d_valid  input  1  data request.
REQ-009 d_addr  input  64  data address.
REQ-010 d_size  input  3  access size code (msize_t).
REQ-011 d_strobe  input  8  byte write enables; 0 means read.
REQ-012 d_wdata  input  64  store data.
REQ-013 d_data_ok  output  1  one-cycle data completion pulse.
REQ-014 d_rdata  output  64  load data, valid with d_data_ok.
REQ-015 c_valid  output  1  shared memory-port request.
REQ-016 c_addr  output  64  request address.
REQ-017 c_size  output  3  request size.
REQ-018 c_strobe  output  8  request write strobes.
REQ-019 c_wdata  output  64  request write data.
REQ-020 c_ready  input  1  memory completion (single beat).
REQ-021 c_rdata  input  64  memory read data, valid with c_ready.

Function
REQ-022 FSM states: IDLE, SERVE_I, SERVE_D.
REQ-023 IDLE with d_valid only -> SERVE_D; i_valid only -> SERVE_I; neither -> stay in IDLE.
REQ-024 IDLE with both valid -> SERVE_D, unless age_cnt == AGE_LIMIT, in which case -> SERVE_I.
REQ-025 On the IDLE->SERVE transition, c_addr/c_size/c_strobe/c_wdata register the winner's fields; for instruction: size = 4-byte code, strobe = 0, wdata = 0.
REQ-026 c_valid is registered: 1 in every SERVE cycle, 0 in IDLE.
REQ-027 In SERVE_x, c_ready = 1 -> x_data_ok = 1 combinationally in the same cycle; state -> IDLE next cycle.
REQ-028 i_data = c_addr[2] ? c_rdata[63:32] : c_rdata[31:0].
REQ-029 d_rdata = c_rdata, unmodified.
REQ-030 A data_ok is never asserted outside its matching SERVE state; i_data_ok and d_data_ok are never both 1.
REQ-031 Minimum latency: x_valid rises in cycle N, c_valid = 1 in cycle N+1, data_ok in N+1 if c_ready; one IDLE bubble between back-to-back transactions.
REQ-032 Requesters hold valid and fields until their data_ok; changes to them during SERVE are ignored, because the latched copies drive the port.
REQ-033 A requester dropping valid mid-service is a protocol violation: the transaction still completes and data_ok still pulses.
REQ-034 age_cnt is 3 bits and saturates at AGE_LIMIT.
REQ-035 age_cnt increments when SERVE_D is entered while i_valid = 1.
REQ-036 age_cnt clears to 0 on entering SERVE_I.
REQ-037 age_cnt clears to 0 in any IDLE cycle with i_valid = 0.
REQ-038 The memory port holds c_valid and its fields stable until c_ready; there is no timeout.

Reset
REQ-039 rst asserted: state = IDLE, age_cnt = 0, and all c_* outputs = 0 immediately, without waiting for a clock edge.
REQ-040 rst asserted: both data_ok outputs are 0 and i_data/d_rdata are don't-care.
REQ-041 Reset mid-transaction abandons the transaction; no data_ok is issued for it.
REQ-042 The first grant is possible on the first clk edge after rst deasserts.

Structure
REQ-043 Shared package arb_pkg holds: arb_state_t (IDLE/SERVE_I/SERVE_D), msize_t with the MSIZE4 code, and the AGE_LIMIT default.
REQ-044 Single module with no sub-modules; the priority pick is an inline always_comb block.

Verification
REQ-045 Reset, then i_valid=1, addr=0x8000_0004, c_ready=1 in the first SERVE cycle, c_rdata=0x1111_2222_3333_4444 -> c_valid at cycle 1, i_data_ok=1, i_data=0x1111_2222.
REQ-046 i_valid and d_valid both 1 from cycle 0 -> SERVE_D first (d_data_ok), one IDLE cycle, then SERVE_I (i_data_ok).
REQ-047 i_valid held high, d_valid re-asserted after every d_data_ok, c_ready=1 -> exactly 4 data grants, then 1 instruction grant, then data again.
REQ-048 Store, d_strobe=0xFF, d_wdata=0xDEAD, c_ready low for 5 cycles -> c_valid and fields stable 5 cycles, single d_data_ok on cycle 6.
REQ-049 rst pulsed during SERVE_D with c_ready=0 -> c_valid=0 asynchronously, no d_data_ok, and the next request is granted normally.
